dmem_bus_bridge: RTL and testbench



---
 rtl/dmem_bus_bridge.sv | 143 ++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// Data-memory bridge: posts CPU stores into an in-order write buffer and turns
// loads into stalled req/ack bus reads once every older store has been acked.
module dmem_bus_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  wbuf_empty,
  output logic [1:0]            dbgState
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(WBUF_DEPTH);
  localparam logic [PW:0] ONE_COUNT  = (PW+1)'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] wbAddr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] wbData [WBUF_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         nextHead;
  logic [PW:0]           count;
  logic [PW:0]           nextCount;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Full is judged on the start-of-cycle count, so a pop cannot make room
  // for a push in the same cycle. A simultaneous load wins over a store.
  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign push       = cpu_we & ~cpu_re & ~full;
  assign pop        = (state == WRITE) & bus_ack;
  assign nextHead   = head + 1'b1;
  assign cpu_stall  = (cpu_re & (state != RESP)) | (cpu_we & full);
  assign wbuf_empty = empty;
  assign dbgState   = state;

  always_comb begin
    nextCount = count;
    if (push && !pop) begin
      nextCount = count + 1'b1;
    end else if (pop && !push) begin
      nextCount = count - 1'b1;
    end
  end

  // Entry storage is not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      wbAddr[tail] <= cpu_addr;
      wbData[tail] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      count <= nextCount;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= nextHead;

      case (state)
        IDLE: begin
          if (!empty) begin
            state     <= WRITE;
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= wbAddr[head];
            bus_wdata <= wbData[head];
          end else if (cpu_re) begin
            state    <= READ;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= cpu_addr;
          end else begin
            bus_req <= 1'b0;
          end
        end
        WRITE: begin
          if (bus_ack) begin
            if (nextCount != '0) begin
              // With only the acked entry left, the survivor is the store
              // being pushed right now and has not reached storage yet.
              bus_addr  <= (count > ONE_COUNT) ? wbAddr[nextHead] : cpu_addr;
              bus_wdata <= (count > ONE_COUNT) ? wbData[nextHead] : cpu_wdata;
            end else if (cpu_re) begin
              state    <= READ;
              bus_we   <= 1'b0;
              bus_addr <= cpu_addr;
            end else begin
              state   <= IDLE;
              bus_req <= 1'b0;
            end
          end
        end
        READ: begin
          if (bus_ack) begin
            cpu_rdata <= bus_rdata;
            bus_req   <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: a directed cycle table, hand-written corner
// sequences, and random load/store traffic against a memory-ordering model.
module tb_dmem_bus_bridge;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] cpu_addr  = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_we    = 1'b0;
  logic          cpu_re    = 1'b0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          wbuf_empty;
  logic [1:0]    dbgState;

  // Bus slave: either scripted (manual) or a random-latency memory (auto)
  logic          autoSlave = 1'b0;
  logic          autoAck   = 1'b0;
  logic [DW-1:0] autoRdata = '0;
  logic          manAck    = 1'b0;
  logic [DW-1:0] manRdata  = '0;
  assign bus_ack   = autoSlave ? autoAck   : manAck;
  assign bus_rdata = autoSlave ? autoRdata : manRdata;

  dmem_bus_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wbuf_empty(wbuf_empty), .dbgState(dbgState)
  );

  // Reference model: memory as the CPU believes it (shadow), memory as the
  // bus slave holds it (slaveMem), and the stores still owed to the bus.
  logic [DW-1:0]    shadow   [16];
  logic [DW-1:0]    slaveMem [16];
  logic [AW+DW-1:0] expQ[$];
  logic             monOn = 1'b0;
  int               writesSeen = 0;
  int               checks = 0;
  int               passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    #2;
    autoAck   = bus_req && ($urandom_range(0, 2) == 0);
    autoRdata = slaveMem[bus_addr[5:2]];
  end

  // Scoreboard: bus writes must match posted stores in order; a read may
  // only complete once every posted store has been written.
  always @(negedge clk) begin
    if (monOn && !rst && bus_req && bus_ack) begin
      if (bus_we) begin
        writesSeen++;
        check("wr_expected", 64'(expQ.size() != 0), 64'(1));
        if (expQ.size() != 0) begin
          check("wr_order", 64'({bus_addr, bus_wdata}), 64'(expQ.pop_front()));
          slaveMem[bus_addr[5:2]] = bus_wdata;
        end
      end else begin
        check("rd_after_drain", 64'(expQ.size()), 64'(0));
      end
    end
  end

  always @(negedge clk)
    assert (!(cpu_we && cpu_re)) else $error("FAIL illegal cpu_we and cpu_re together");

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: called at posedge+1, return at posedge+1 after acceptance
  task automatic store_op(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit track, input string tag, output int n);
    n = 0;
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (cpu_stall && n < 100) begin n++; @(negedge clk); end
    check({tag, "_accept"}, 64'(cpu_stall), 64'(0));
    if (track) begin
      expQ.push_back({a, d});
      shadow[a[5:2]] = d;
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  task automatic load_op(input logic [AW-1:0] a, input string tag, output int n);
    n = 0;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    while (cpu_stall && n < 100) begin n++; @(negedge clk); end
    check({tag, "_done"}, 64'(cpu_stall), 64'(0));
    check({tag, "_data"}, 64'(cpu_rdata), 64'(shadow[a[5:2]]));
    @(posedge clk); #1;
    cpu_re = 1'b0;
  endtask

  typedef struct {
    logic          we, re, ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic          expStall, expReq, chkBus, expWe, chkWdata, expEmpty;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata, expRdata;
  } vec_t;

  function automatic vec_t mkv(input logic [2:0] ctl, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                               input logic [5:0] flags, input logic [AW-1:0] ba,
                               input logic [DW-1:0] bwd, input logic [DW-1:0] rd);
    vec_t v;
    {v.we, v.re, v.ack} = ctl;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    {v.expStall, v.expReq, v.chkBus, v.expWe, v.chkWdata, v.expEmpty} = flags;
    v.expAddr = ba; v.expWdata = bwd; v.expRdata = rd;
    return v;
  endfunction

  vec_t vecs[12];
  int   n;
  int   r;
  int   w0;
  logic [AW-1:0] a;
  logic [DW-1:0] d;

  initial begin
    // Flags: {stall, req, chkBus, bus_we, chkWdata, wbuf_empty}
    vecs[0]  = mkv(3'b100, 32'h10, 32'hDEADBEEF, 32'h0, 6'b000001, 32'h0, 32'h0, 32'h0);
    vecs[1]  = mkv(3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0, 32'h0);
    vecs[2]  = mkv(3'b000, 32'h0, 32'h0, 32'h0, 6'b011110, 32'h10, 32'hDEADBEEF, 32'h0);
    vecs[3]  = mkv(3'b000, 32'h0, 32'h0, 32'h0, 6'b011110, 32'h10, 32'hDEADBEEF, 32'h0);
    vecs[4]  = mkv(3'b001, 32'h0, 32'h0, 32'h0, 6'b011110, 32'h10, 32'hDEADBEEF, 32'h0);
    vecs[5]  = mkv(3'b000, 32'h0, 32'h0, 32'h0, 6'b000001, 32'h0, 32'h0, 32'h0);
    vecs[6]  = mkv(3'b010, 32'h20, 32'h0, 32'h0, 6'b100001, 32'h0, 32'h0, 32'h0);
    vecs[7]  = mkv(3'b011, 32'h20, 32'h0, 32'h12345678, 6'b111001, 32'h20, 32'h0, 32'h0);
    vecs[8]  = mkv(3'b010, 32'h20, 32'h0, 32'h0, 6'b000001, 32'h0, 32'h0, 32'h12345678);
    vecs[9]  = mkv(3'b000, 32'h0, 32'h0, 32'h0, 6'b000001, 32'h0, 32'h0, 32'h12345678);
    vecs[10] = mkv(3'b001, 32'h0, 32'h0, 32'hFFFF0000, 6'b000001, 32'h0, 32'h0, 32'h12345678);
    vecs[11] = mkv(3'b000, 32'h0, 32'h0, 32'h0, 6'b000001, 32'h0, 32'h0, 32'h12345678);

    for (int i = 0; i < 16; i++) begin
      shadow[i]   = 32'h01010101 * i;
      slaveMem[i] = 32'h01010101 * i;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req", 64'(bus_req), 64'(0));
    check("rst_we", 64'(bus_we), 64'(0));
    check("rst_addr", 64'(bus_addr), 64'(0));
    check("rst_wdata", 64'(bus_wdata), 64'(0));
    check("rst_rdata", 64'(cpu_rdata), 64'(0));
    check("rst_empty", 64'(wbuf_empty), 64'(1));
    check("rst_stall", 64'(cpu_stall), 64'(0));
    @(posedge clk); #1;

    // Directed table: single store, single load, stray ack while idle
    for (int i = 0; i < 12; i++) begin
      cpu_we = vecs[i].we; cpu_re = vecs[i].re; cpu_addr = vecs[i].addr;
      cpu_wdata = vecs[i].wdata; manAck = vecs[i].ack; manRdata = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("vec%0d_stall(st%0d)", i, dbgState), 64'(cpu_stall), 64'(vecs[i].expStall));
      check($sformatf("vec%0d_req", i), 64'(bus_req), 64'(vecs[i].expReq));
      check($sformatf("vec%0d_empty", i), 64'(wbuf_empty), 64'(vecs[i].expEmpty));
      check($sformatf("vec%0d_rdata", i), 64'(cpu_rdata), 64'(vecs[i].expRdata));
      if (vecs[i].chkBus) begin
        check($sformatf("vec%0d_we", i), 64'(bus_we), 64'(vecs[i].expWe));
        check($sformatf("vec%0d_addr", i), 64'(bus_addr), 64'(vecs[i].expAddr));
      end
      if (vecs[i].chkWdata)
        check($sformatf("vec%0d_wdata", i), 64'(bus_wdata), 64'(vecs[i].expWdata));
      @(posedge clk); #1;
    end
    cpu_we = 1'b0; cpu_re = 1'b0; manAck = 1'b0;

    // Five stores into a four-entry buffer with acks withheld
    monOn = 1'b1;
    w0 = writesSeen;
    for (int i = 0; i < 4; i++) begin
      store_op(32'(i * 4), $urandom(), 1'b1, $sformatf("fill%0d", i), n);
      check($sformatf("fill%0d_nostall", i), 64'(n), 64'(0));
    end
    d = $urandom();
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = d;
    @(negedge clk);
    check("full_stall", 64'(cpu_stall), 64'(1));
    @(posedge clk); #1 manAck = 1'b1;
    @(negedge clk);
    check("full_refuse_on_pop", 64'(cpu_stall), 64'(1));
    @(posedge clk); #1 manAck = 1'b0;
    @(negedge clk);
    check("full_accept_after_pop", 64'(cpu_stall), 64'(0));
    expQ.push_back({32'h10, d});
    shadow[4] = d;
    @(posedge clk); #1 cpu_we = 1'b0; manAck = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(wbuf_empty && !bus_req) && n < 50) begin n++; @(negedge clk); end
    check("fill_drained", 64'(wbuf_empty), 64'(1));
    check("fill_queue", 64'(expQ.size()), 64'(0));
    check("fill_writes", 64'(writesSeen - w0), 64'(5));
    @(posedge clk); #1 manAck = 1'b0;

    // Store then load of the same address on the next cycle
    autoSlave = 1'b1;
    store_op(32'h30, 32'hA5A5A5A5, 1'b1, "raw_st", n);
    load_op(32'h30, "raw_ld", n);
    check("raw_min_stall", 64'(n >= 3), 64'(1));
    check("raw_value", 64'(shadow[12]), 64'(32'hA5A5A5A5));

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 15) * 4;
      if (r < 4) store_op(a, $urandom(), 1'b1, "rnd_st", n);
      else if (r < 8) load_op(a, "rnd_ld", n);
      else begin @(posedge clk); #1; end
    end
    n = 0;
    @(negedge clk);
    while (!(wbuf_empty && !bus_req) && n < 200) begin n++; @(negedge clk); end
    check("rnd_drained", 64'(wbuf_empty), 64'(1));
    check("rnd_queue", 64'(expQ.size()), 64'(0));
    @(posedge clk); #1;

    // Reset with stores still buffered, then reset during a read
    monOn = 1'b0; autoSlave = 1'b0; manAck = 1'b0;
    for (int i = 0; i < 3; i++) store_op(32'(32'h40 + i * 4), $urandom(), 1'b0, "rs_st", n);
    @(negedge clk);
    check("rs_pre_req", 64'(bus_req), 64'(1));
    check("rs_pre_empty", 64'(wbuf_empty), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rs_req", 64'(bus_req), 64'(0));
    check("rs_stall", 64'(cpu_stall), 64'(0));
    check("rs_empty", 64'(wbuf_empty), 64'(1));
    @(posedge clk); #1 manAck = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rs_ack_ignored_req", 64'(bus_req), 64'(0));
    check("rs_ack_ignored_empty", 64'(wbuf_empty), 64'(1));
    check("rs_ack_ignored_rdata", 64'(cpu_rdata), 64'(0));
    @(posedge clk); #1 manAck = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h44;
    @(negedge clk);
    check("rr_stall", 64'(cpu_stall), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_pre_req", 64'(bus_req), 64'(1));
    check("rr_pre_we", 64'(bus_we), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; cpu_re = 1'b0;
    @(negedge clk);
    check("rr_req", 64'(bus_req), 64'(0));
    check("rr_stall_after", 64'(cpu_stall), 64'(0));
    check("rr_empty", 64'(wbuf_empty), 64'(1));
    @(posedge clk); #1 manAck = 1'b1; manRdata = 32'hBADBAD00;
    @(posedge clk); #1 manAck = 1'b0;
    @(negedge clk);
    check("rr_ack_ignored_req", 64'(bus_req), 64'(0));
    check("rr_ack_ignored_rdata", 64'(cpu_rdata), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
